butterfly_pipe: RTL and testbench
=================================

Name: butterfly_pipe

Overview:
- Parametrised, pipelined radix-2 DIT butterfly computing X0 = A + W·B and X1 = A − W·B on packed complex samples; the successor to the combinational butterfly_unit.
- Adds generic data/twiddle widths, a valid/ready stream handshake with full backpressure, per-sample inverse (conjugate twiddle) and scale-by-½ modes, rounding, saturation and overflow reporting.
- Sits between the FFT sample buffer and the stage-to-stage reorder memory.

Parameters:
DW, 16, signed width of each real/imag component of A, B, X0, X1
TW, 16, signed width of each twiddle component, Q1.(TW−1) format

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept input this cycle
a_in  in  2*DW  {re, im} of A, re in upper half
b_in  in  2*DW  {re, im} of B
w_in  in  2*TW  {re, im} of twiddle W
inv_in  in  1  1 = use conj(W), for IFFT
scale_in  in  1  1 = divide both outputs by 2
out_valid  out  1  output valid
out_ready  in  1  downstream accepts output
x0_out  out  2*DW  {re, im} of A + W·B
x1_out  out  2*DW  {re, im} of A − W·B
ovf_out  out  1  saturation occurred on this output sample; qualified by out_valid
ovf_sticky  out  1  set by any saturation, held until cleared
clr_ovf  in  1  synchronous clear of ovf_sticky

Behaviour:
- One clock domain: clk. Reset: rst_n, asynchronous, active-low.
- Reset state: all stage valids 0; out_valid=0; x0_out=x1_out=0; ovf_out=0; ovf_sticky=0. in_ready=1 once out of reset.
- A reset asserted mid-operation discards all in-flight samples immediately. No partial output is produced.
- Pipeline: 3 stages, latency 3.
  - S1 registers the inputs and the mode bits.
  - S2 holds the full-precision complex product.
  - S3 holds round, add/sub, scale and saturate.
  - A sample accepted on edge k presents on out_valid at edge k+3 when there is no stall.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - stall = out_valid && !out_ready. On a stall, all stages hold.
  - in_ready = !stall.
  - Bubbles are not compressed.
  - Outputs are held stable while stalled.
  - Ordering is strictly FIFO. No sample is dropped or duplicated.
- Mode bits inv_in and scale_in are captured with each sample and travel with it. Modes may change every sample.
- Product, in full precision:
  - p_re = Wr·Br − s·Wi·Bi
  - p_im = Wr·Bi + s·Wi·Br
  - s = +1 normally, −1 when inv = 1.
  - Conjugation is done by subtracting the product terms, never by negating Wi, so Wi = −2^(TW−1) is exact.
  - Width of the full-precision terms: DW+TW+1.
- Rounding: add 2^(TW−2), then arithmetic shift right by TW−1 (round half up). Result width is DW+2.
- Sums: s0 = A + p and s1 = A − p, per component, at DW+3 bits.
- Scale: when scale=1, each component becomes (s + 1) >>> 1 (round half up).
- Saturation:
  - Clamp each component to [−2^(DW−1), 2^(DW−1)−1].
  - ovf_out = OR of the clamp events across all 4 components.
- Sticky flag:
  - ovf_sticky is set on an output transfer with ovf_out=1.
  - clr_ovf clears it.
  - If a clear and a set occur in the same cycle, the set wins.

Decomposition:
- Package bfly_pkg holds:
  - typedefs for the complex data (DW) and twiddle (TW) structs;
  - pack/unpack functions;
  - a sat() function parametrised by input width;
  - the LAT=3 constant.
- One natural sub-module, cmul_round: a registered complex multiply with inv handling and rounding. It implements S2 plus the rounding logic and carries the stall enable.

Test Plan:
- Identity twiddle (DW=TW=16): A=(100,50), B=(20,−10), W=(32767,0), inv=0, scale=0 -> 3 cycles later X0=(120,40), X1=(80,60), ovf_out=0.
- −j twiddle and inverse: A=(0,0), B=(1000,0), W=(0,−32768).
  - inv=0 -> X0=(0,−1000), X1=(0,1000).
  - Same sample with inv=1 -> X0=(0,1000), X1=(0,−1000).
- Saturation and scale: A=B=(32767,−32768), W=(32767,0).
  - scale=0 -> X0=(32767,−32768), X1=(1,−1), ovf_out=1, ovf_sticky=1.
  - scale=1 -> X0=(32767,−32767), X1=(1,0), ovf_out=0.
- Backpressure: stream 8 distinct samples back-to-back with out_ready low for cycles 4–9 -> in_ready low exactly while stalled; outputs held stable; all 8 results emerge in order, none lost or duplicated.
- Reset mid-operation: 3 samples in flight, pulse rst_n low asynchronously between edges -> out_valid, x0_out, x1_out and ovf_sticky go to 0 immediately; none of the 3 samples appears after release.
- Sticky clear collision: assert clr_ovf in the same cycle as an overflowing output transfer -> ovf_sticky=1. clr_ovf alone on the next cycle -> ovf_sticky=0.

Source files
------------

// File: rtl/bfly_pkg.sv
// Shared types, constants and arithmetic helpers for the butterfly datapath.
package bfly_pkg;

  localparam int unsigned Lat   = 3;
  localparam int unsigned DwDef = 16;
  localparam int unsigned TwDef = 16;
  // Working width for the generic helpers; all datapath widths must fit inside it.
  localparam int unsigned SatW  = 64;

  typedef struct packed {
    logic signed [DwDef-1:0] re;
    logic signed [DwDef-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TwDef-1:0] re;
    logic signed [TwDef-1:0] im;
  } twid_t;

  typedef struct packed {
    logic                   ovf;
    logic signed [SatW-1:0] val;
  } sat_t;

  // Sign-extended real part (upper half) of a packed {re, im} bus of component width w.
  function automatic logic signed [SatW-1:0] get_re(input logic [2*SatW-1:0] bus,
                                                    input int unsigned w);
    logic signed [2*SatW-1:0] t;
    t = bus << (2*SatW - 2*w);
    t = t >>> (2*SatW - w);
    return t[SatW-1:0];
  endfunction

  // Sign-extended imaginary part (lower half) of a packed {re, im} bus.
  function automatic logic signed [SatW-1:0] get_im(input logic [2*SatW-1:0] bus,
                                                    input int unsigned w);
    logic signed [2*SatW-1:0] t;
    t = bus << (2*SatW - w);
    t = t >>> (2*SatW - w);
    return t[SatW-1:0];
  endfunction

  // Packs two components into {re, im}, each truncated to w bits.
  function automatic logic [2*SatW-1:0] pack_cplx(input logic signed [SatW-1:0] re,
                                                   input logic signed [SatW-1:0] im,
                                                   input int unsigned w);
    logic [2*SatW-1:0] mask;
    mask = ((2*SatW)'(1) << w) - (2*SatW)'(1);
    return (((2*SatW)'(re) & mask) << w) | ((2*SatW)'(im) & mask);
  endfunction

  // Clamps a sign-extended value of any narrower width to a signed out_w range.
  function automatic sat_t sat(input logic signed [SatW-1:0] x, input int unsigned out_w);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    sat_t r;
    hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (out_w - 1));
    r.ovf = (x > hi) || (x < lo);
    r.val = (x > hi) ? hi : ((x < lo) ? lo : x);
    return r;
  endfunction

endpackage

// File: rtl/cmul_round.sv
// Registered complex multiply W*B (or conj(W)*B) followed by a registered
// round-half-up back to DW+2 bits. A side-band tag travels alongside.
module cmul_round
  import bfly_pkg::*;
#(
  parameter int unsigned DW   = DwDef,
  parameter int unsigned TW   = TwDef,
  parameter int unsigned TagW = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [TagW-1:0]      tag_i,
  input  logic signed [DW-1:0] b_re_i,
  input  logic signed [DW-1:0] b_im_i,
  input  logic signed [TW-1:0] w_re_i,
  input  logic signed [TW-1:0] w_im_i,
  input  logic                 inv_i,
  output logic [TagW-1:0]      tag_o,
  output logic signed [DW+1:0] p_re_o,
  output logic signed [DW+1:0] p_im_o
);

  localparam int unsigned PW = DW + TW + 1;
  localparam int unsigned RW = DW + 2;
  localparam logic signed [PW-1:0] RndC = {{(PW-1){1'b0}}, 1'b1} << (TW - 2);

  logic signed [PW-1:0] t_rr, t_ii, t_ri, t_ir;
  logic signed [PW-1:0] prod_re_d, prod_re_q, prod_im_d, prod_im_q;
  logic signed [RW-1:0] p_re_d, p_re_q, p_im_d, p_im_q;
  logic [TagW-1:0]      tag_p_q, tag_r_q;

  // Full-precision product; conjugation flips the sign of the Wi terms, never Wi itself.
  always_comb begin
    t_rr      = PW'(w_re_i) * PW'(b_re_i);
    t_ii      = PW'(w_im_i) * PW'(b_im_i);
    t_ri      = PW'(w_re_i) * PW'(b_im_i);
    t_ir      = PW'(w_im_i) * PW'(b_re_i);
    prod_re_d = inv_i ? (t_rr + t_ii) : (t_rr - t_ii);
    prod_im_d = inv_i ? (t_ri - t_ir) : (t_ri + t_ir);
    p_re_d    = RW'((prod_re_q + RndC) >>> (TW - 1));
    p_im_d    = RW'((prod_im_q + RndC) >>> (TW - 1));
  end

  // Product and rounded-product registers, both frozen while the pipe is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_re_q <= '0;
      prod_im_q <= '0;
      p_re_q    <= '0;
      p_im_q    <= '0;
      tag_p_q   <= '0;
      tag_r_q   <= '0;
    end else if (en_i) begin
      prod_re_q <= prod_re_d;
      prod_im_q <= prod_im_d;
      p_re_q    <= p_re_d;
      p_im_q    <= p_im_d;
      tag_p_q   <= tag_i;
      tag_r_q   <= tag_p_q;
    end
  end

  assign tag_o  = tag_r_q;
  assign p_re_o = p_re_q;
  assign p_im_o = p_im_q;

endmodule

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly with valid/ready flow control, per-sample
// inverse and halving modes, saturation and a sticky overflow flag.
module butterfly_pipe
  import bfly_pkg::*;
#(
  parameter int unsigned DW = DwDef,
  parameter int unsigned TW = TwDef
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] a_in,
  input  logic [2*DW-1:0] b_in,
  input  logic [2*TW-1:0] w_in,
  input  logic            inv_in,
  input  logic            scale_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] x0_out,
  output logic [2*DW-1:0] x1_out,
  output logic            ovf_out,
  output logic            ovf_sticky,
  input  logic            clr_ovf
);

  localparam int unsigned TagW = 2*DW + 2;
  localparam int unsigned SW   = DW + 3;

  typedef struct packed {
    logic            valid;
    logic            inv;
    logic            scale;
    logic [2*DW-1:0] a;
    logic [2*DW-1:0] b;
    logic [2*TW-1:0] w;
  } s1_t;

  logic                 en;
  s1_t                  s1_d, s1_q;
  logic signed [DW-1:0] b_re, b_im;
  logic signed [TW-1:0] w_re, w_im;
  logic [TagW-1:0]      tag_in, tag_out;
  logic signed [DW+1:0] p_re, p_im;
  logic                 tag_valid, tag_scale;
  logic [2*DW-1:0]      tag_a;
  logic signed [SW-1:0] a_re, a_im;
  logic signed [SW-1:0] sum [4];
  sat_t                 sat_r [4];
  logic [2*DW-1:0]      x0_d, x0_q, x1_d, x1_q;
  logic                 valid_d, valid_q, ovf_d, ovf_q, sticky_d, sticky_q;

  // Rounded half-up halving of a sum, applied only in scale mode.
  function automatic logic signed [SW-1:0] half(input logic signed [SW-1:0] v, input logic on);
    return on ? ((v + SW'(1)) >>> 1) : v;
  endfunction

  // Every stage advances together unless the output is waiting on the sink.
  assign en       = !(valid_q && !out_ready);
  assign in_ready = en;

  // S1: capture the sample and its mode bits.
  always_comb begin
    s1_d = s1_q;
    if (en) begin
      s1_d = '{valid: in_valid, inv: inv_in, scale: scale_in, a: a_in, b: b_in, w: w_in};
    end
    b_re   = DW'(get_re((2*SatW)'(s1_q.b), DW));
    b_im   = DW'(get_im((2*SatW)'(s1_q.b), DW));
    w_re   = TW'(get_re((2*SatW)'(s1_q.w), TW));
    w_im   = TW'(get_im((2*SatW)'(s1_q.w), TW));
    tag_in = {s1_q.valid, s1_q.scale, s1_q.a};
  end

  cmul_round #(
    .DW   (DW),
    .TW   (TW),
    .TagW (TagW)
  ) u_cmul (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (en),
    .tag_i  (tag_in),
    .b_re_i (b_re),
    .b_im_i (b_im),
    .w_re_i (w_re),
    .w_im_i (w_im),
    .inv_i  (s1_q.inv),
    .tag_o  (tag_out),
    .p_re_o (p_re),
    .p_im_o (p_im)
  );

  // S3: add/sub, optional halving, saturation; sticky flag set on overflowing transfers.
  always_comb begin
    {tag_valid, tag_scale, tag_a} = tag_out;
    a_re   = SW'(get_re((2*SatW)'(tag_a), DW));
    a_im   = SW'(get_im((2*SatW)'(tag_a), DW));
    sum[0] = half(a_re + SW'(p_re), tag_scale);
    sum[1] = half(a_im + SW'(p_im), tag_scale);
    sum[2] = half(a_re - SW'(p_re), tag_scale);
    sum[3] = half(a_im - SW'(p_im), tag_scale);
    for (int i = 0; i < 4; i++) begin
      sat_r[i] = sat(SatW'(sum[i]), DW);
    end
    valid_d = valid_q;
    ovf_d   = ovf_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    if (en) begin
      valid_d = tag_valid;
      ovf_d   = tag_valid & (sat_r[0].ovf | sat_r[1].ovf | sat_r[2].ovf | sat_r[3].ovf);
      x0_d    = (2*DW)'(pack_cplx(sat_r[0].val, sat_r[1].val, DW));
      x1_d    = (2*DW)'(pack_cplx(sat_r[2].val, sat_r[3].val, DW));
    end
    sticky_d = (sticky_q & ~clr_ovf) | (valid_q & out_ready & ovf_q);
  end

  // Pipeline and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      x0_q     <= '0;
      x1_q     <= '0;
      sticky_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = valid_q;
  assign x0_out     = x0_q;
  assign x1_out     = x1_q;
  assign ovf_out    = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed bench for butterfly_pipe: vector table plus flow-control, reset and sticky sequences.
module tb_butterfly_pipe;
  import bfly_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0, in_ready, inv_in = 1'b0, scale_in = 1'b0;
  logic        out_valid, out_ready = 1'b1, ovf_out, ovf_sticky, clr_ovf = 1'b0;
  logic [31:0] a_in = '0, b_in = '0, w_in = '0, x0_out, x1_out;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    string name;
    int    ar, ai, br, bi, wr, wi;
    bit    inv, scale;
    int    x0r, x0i, x1r, x1i;
    bit    ovf;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  butterfly_pipe #(.DW(16), .TW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .w_in       (w_in),
    .inv_in     (inv_in),
    .scale_in   (scale_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .x0_out     (x0_out),
    .x1_out     (x1_out),
    .ovf_out    (ovf_out),
    .ovf_sticky (ovf_sticky),
    .clr_ovf    (clr_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_cplx(input string name, input logic [31:0] act, input int re, input int im);
    cplx_t a;
    cplx_t e;
    a    = act;
    e.re = 16'(re);
    e.im = 16'(im);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d)", name, a.re, a.im, re, im);
    end
  endtask

  task automatic drive(input int ar, input int ai, input int br, input int bi,
                       input int wr, input int wi, input bit inv, input bit scale);
    a_in     = {16'(ar), 16'(ai)};
    b_in     = {16'(br), 16'(bi)};
    w_in     = {16'(wr), 16'(wi)};
    inv_in   = inv;
    scale_in = scale;
  endtask

  // Sends one sample into an empty pipe and checks latency and results; ends at edge k+3.
  task automatic apply_vec(input vec_t v);
    drive(v.ar, v.ai, v.br, v.bi, v.wr, v.wi, v.inv, v.scale);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk_bit({v.name, "_early"}, out_valid, 1'b0);
    step();
    chk_bit({v.name, "_valid"}, out_valid, 1'b1);
    chk_cplx({v.name, "_x0"}, x0_out, v.x0r, v.x0i);
    chk_cplx({v.name, "_x1"}, x1_out, v.x1r, v.x1i);
    chk_bit({v.name, "_ovf"}, ovf_out, v.ovf);
    chk_bit({v.name, "_sticky"}, ovf_sticky, 1'b0);
  endtask

  initial begin
    int sent;
    int rx;
    int seen;

    vecs[0] = '{"ident", 100, 50, 20, -10, 32767, 0, 1'b0, 1'b0, 120, 40, 80, 60, 1'b0};
    vecs[1] = '{"mj_fwd", 0, 0, 1000, 0, 0, -32768, 1'b0, 1'b0, 0, -1000, 0, 1000, 1'b0};
    vecs[2] = '{"mj_inv", 0, 0, 1000, 0, 0, -32768, 1'b1, 1'b0, 0, 1000, 0, -1000, 1'b0};
    vecs[3] = '{"gen_fwd", -5, 7, 3, 4, 16384, 16384, 1'b0, 1'b0, -5, 11, -5, 3, 1'b0};
    vecs[4] = '{"gen_inv", -5, 7, 3, 4, 16384, 16384, 1'b1, 1'b0, -1, 8, -9, 6, 1'b0};
    vecs[5] = '{"half_rnd", 3, -3, 0, 0, 0, 0, 1'b0, 1'b1, 2, -1, 2, -1, 1'b0};
    vecs[6] = '{"sat_scl", 32767, -32768, 32767, -32768, 32767, 0, 1'b0, 1'b1,
                32767, -32767, 1, 0, 1'b0};
    vecs[7] = '{"sat", 32767, -32768, 32767, -32768, 32767, 0, 1'b0, 1'b0,
                32767, -32768, 1, -1, 1'b1};

    // Reset state.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_cplx("rst_x0", x0_out, 0, 0);
    chk_cplx("rst_x1", x1_out, 0, 0);
    chk_bit("rst_ovf", ovf_out, 1'b0);
    chk_bit("rst_sticky", ovf_sticky, 1'b0);
    #5 rst_n = 1'b1;
    step();
    chk_bit("rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      apply_vec(vecs[i]);
    end

    // The overflowing sample transfers on the next edge.
    step();
    chk_bit("sticky_set", ovf_sticky, 1'b1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk_bit("sticky_clr", ovf_sticky, 1'b0);

    // Clear colliding with an overflowing transfer: set wins, then a lone clear works.
    apply_vec(vecs[7]);
    clr_ovf = 1'b1;
    step();
    chk_bit("coll_set_wins", ovf_sticky, 1'b1);
    step();
    clr_ovf = 1'b0;
    chk_bit("coll_clr_next", ovf_sticky, 1'b0);

    // Backpressure: 8 samples back to back, sink stalls windows 4..9.
    sent = 0;
    rx   = 0;
    for (int w = 0; w < 30; w++) begin
      out_ready = !(w >= 4 && w <= 9);
      if (sent < 8) begin
        drive(10*(sent+1), -(sent+1), sent+1, 2*(sent+1), 32767, 0, 1'b0, 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk_bit("bp_in_ready", in_ready, !(w >= 4 && w <= 9));
      if (w == 3) chk_bit("bp_lat_early", out_valid, 1'b0);
      if (w == 4) chk_bit("bp_lat_first", out_valid, 1'b1);
      if (out_valid) begin
        if (rx >= 8) begin
          n_chk++;
          n_fail++;
          $display("FAIL bp_extra: got sample index %0d required at most 8 samples", rx);
        end else begin
          chk_cplx("bp_x0", x0_out, 11*(rx+1), rx+1);
          chk_cplx("bp_x1", x1_out, 9*(rx+1), -3*(rx+1));
        end
        if (out_ready) rx++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_chk++;
    if (rx != 8 || sent != 8) begin
      n_fail++;
      $display("FAIL bp_count: got sent=%0d received=%0d required 8 and 8", sent, rx);
    end
    chk_bit("bp_drained", out_valid, 1'b0);

    // Reset mid-operation with sticky set and 3 samples in flight.
    apply_vec(vecs[7]);
    step();
    chk_bit("pre_rst_sticky", ovf_sticky, 1'b1);
    out_ready = 1'b0;
    for (int w = 0; w < 5; w++) begin
      if (w < 3) begin
        drive(10*(w+1), -(w+1), w+1, 2*(w+1), 32767, 0, 1'b0, 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (w < 4) step();
    end
    chk_bit("pre_rst_valid", out_valid, 1'b1);
    chk_cplx("pre_rst_x0", x0_out, 11, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_bit("mid_rst_valid", out_valid, 1'b0);
    chk_cplx("mid_rst_x0", x0_out, 0, 0);
    chk_cplx("mid_rst_x1", x1_out, 0, 0);
    chk_bit("mid_rst_sticky", ovf_sticky, 1'b0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int w = 0; w < 10; w++) begin
      step();
      if (out_valid) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL post_rst_ghost: got %0d valid cycles required 0", seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
